fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. Sits directly upstream of imem and drives its 6-bit word address `a`.
- Holds the program counter (PC) and computes next-PC: sequential, branch, or jump.
- Captures imem's 32-bit `rd` into the IF/ID pipeline register, together with PC+4 and a valid bit.
- Supports stall (hold) and flush (bubble insertion) for the hazard unit.

Parameters:
- PC_WIDTH, 32, width of PC, targets and PC+4.
- IMEM_AW, 6, imem word-address width; imem covers 2^IMEM_AW words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  replace next IF/ID contents with a bubble.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  PC_WIDTH  branch destination byte address.
- jump  in  1  redirect to jump_target.
- jump_target  in  PC_WIDTH  jump destination byte address.
- imem_addr  out  IMEM_AW  word address to imem = pc[IMEM_AW+1:2].
- imem_rd  in  32  instruction word returned combinationally by imem.
- pc  out  PC_WIDTH  current fetch PC.
- ifid_instr  out  32  registered instruction.
- ifid_pc4  out  PC_WIDTH  registered PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- align_err  out  1  one-cycle pulse: an accepted redirect target had nonzero bits [1:0].
- range_err  out  1  combinational; high when pc[PC_WIDTH-1:IMEM_AW+2] != 0.
- fetch_count  out  32  number of instructions captured with valid=1.

Behaviour:
- Reset (synchronous, checked at the clock edge), values on the following cycle:
  - pc = RESET_PC; ifid_instr = 0; ifid_pc4 = 0; ifid_valid = 0; align_err = 0; fetch_count = 0.
  - Reset overrides every other input.
- imem_addr = pc[IMEM_AW+1:2], purely combinational.
  - imem is asynchronous-read, so `rd` for the current pc is captured at the same edge that advances pc.
  - Fetch latency is 1 cycle: pc to ifid_instr.
- Next-PC priority (highest first): reset > jump > branch_taken > stall > pc+4.
  - Redirects override stall: a redirect loads its target even while stall=1.
  - jump and branch_taken together: jump wins.
  - Targets are loaded with bits [1:0] forced to 0.
  - align_err is registered: 1 on the cycle after a redirect whose selected target had bits [1:0] != 0, otherwise 0.
- PC arithmetic: pc+4 is modulo 2^PC_WIDTH and wraps silently.
  - imem_addr wraps naturally, e.g. pc=0x100 gives imem_addr=0 with range_err=1.
- IF/ID priority (highest first): reset > flush > stall > capture.
  - flush: ifid_instr=0 (NOP), ifid_pc4=0, ifid_valid=0. flush wins over stall.
  - stall (no flush): all IF/ID fields hold.
  - capture: ifid_instr=imem_rd, ifid_pc4=pc+4, ifid_valid=1.
- fetch_count increments by 1 (wrapping at 2^32) on every capture edge. No increment on stall, flush, or reset.
- A redirect does not invalidate the instruction captured at that same edge; squashing it is the hazard unit's job, done by asserting flush.
- Reset asserted mid-stall or mid-flush: reset values apply on the next cycle. No pending state survives.

Test Plan:
- Reset, then reset=0 for 3 cycles with imem word k = 0x1000_0000+k → pc sequence 0,4,8,C; imem_addr 0,1,2,3; ifid_instr 0x1000_0000/1/2 with ifid_pc4 4/8/C, valid=1; fetch_count=3.
- At pc=8, stall=1 for 2 cycles → pc stays 8; ifid_instr stays 0x1000_0001; fetch_count unchanged. Release → pc=C; ifid_instr=0x1000_0002.
- At pc=C, jump=1, jump_target=0x80, branch_taken=1, branch_target=0x40, stall=1 → pc=0x80 (jump wins, overrides stall); imem_addr=0x20; align_err=0.
- flush=1 and stall=1 together → ifid_valid=0, ifid_instr=0, ifid_pc4=0; fetch_count unchanged. Next cycle with neither asserted → valid=1.
- branch_taken=1, branch_target=0xFE → pc=0xFC; imem_addr=0x3F; align_err pulses 1 for exactly one cycle. Next sequential step → pc=0x100, imem_addr=0, range_err=1.
- reset=1 while stall=1 and pc=0x80 → next cycle pc=0, ifid_valid=0, fetch_count=0, align_err=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Holds the PC, selects next-PC
// (jump / branch / stall / sequential), drives the asynchronous imem word
// address and registers the fetched word into the IF/ID pipeline register.
module fetch_stage #(
   parameter int unsigned           PC_WIDTH = 32,
   parameter int unsigned           IMEM_AW  = 6,
   parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 jump,
   input  logic [PC_WIDTH-1:0]  jump_target,
   output logic [IMEM_AW-1:0]   imem_addr,
   input  logic [31:0]          imem_rd,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [31:0]          ifid_instr,
   output logic [PC_WIDTH-1:0]  ifid_pc4,
   output logic                 ifid_valid,
   output logic                 align_err,
   output logic                 range_err,
   output logic [31:0]          fetch_count
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] pc4;
   logic [31:0]         instr_q, instr_d;
   logic [PC_WIDTH-1:0] pc4_q, pc4_d;
   logic                valid_q, valid_d;
   logic                align_q, align_d;
   logic [31:0]         count_q, count_d;

   assign pc4 = pc_q + PC_WIDTH'(4);

   // Next-state selection for PC, alignment flag and IF/ID register.
   always_comb begin
      pc_d    = pc4;
      align_d = 1'b0;
      instr_d = imem_rd;
      pc4_d   = pc4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;

      // Redirects outrank stall; jump outranks branch.
      if (jump) begin
         pc_d    = {jump_target[PC_WIDTH-1:2], 2'b00};
         align_d = |jump_target[1:0];
      end else if (branch_taken) begin
         pc_d    = {branch_target[PC_WIDTH-1:2], 2'b00};
         align_d = |branch_target[1:0];
      end else if (stall) begin
         pc_d    = pc_q;
      end

      // A same-edge redirect does not squash the captured word; flush does.
      if (flush) begin
         instr_d = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
         count_d = count_q;
      end else if (stall) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
         count_d = count_q;
      end
   end

   // State registers with synchronous reset overriding all other inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         align_q <= 1'b0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         align_q <= align_d;
         count_q <= count_d;
      end
   end

   assign pc          = pc_q;
   assign imem_addr   = pc_q[IMEM_AW+1:2];
   assign range_err   = |pc_q[PC_WIDTH-1:IMEM_AW+2];
   assign ifid_instr  = instr_q;
   assign ifid_pc4    = pc4_q;
   assign ifid_valid  = valid_q;
   assign align_err   = align_q;
   assign fetch_count = count_q;

endmodule
